// File: rtl/addsub_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : addsub_arbiter_if
//  Description : Client-side bus for the shared add/subtract unit. Carries
//                both requesters' level requests, operation selects and
//                operands, and the unit's acknowledge/result signals.
//  Ports       : none (signal bundle only)
//                master modport - used by the requesters / operand sources
//                slave  modport - used by addsub_arbiter
//  Revision    : 1.0  initial release
// ============================================================================
interface addsub_arbiter_if #(
    parameter int WIDTH = 4
) ();

    // Client 0
    logic             req0;
    logic             op0;
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] b0;

    // Client 1
    logic             req1;
    logic             op1;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b1;

    // Completion / result
    logic             ack0;
    logic             ack1;
    logic             valid;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             ovf;
    logic             id;
    logic             busy;

    modport master (
        output req0, op0, a0, b0,
        output req1, op1, a1, b1,
        input  ack0, ack1, valid, result, carry, ovf, id, busy
    );

    modport slave (
        input  req0, op0, a0, b0,
        input  req1, op1, a1, b1,
        output ack0, ack1, valid, result, carry, ovf, id, busy
    );

endinterface
`default_nettype wire

// File: rtl/addsub_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : addsub_arbiter
//  Description : Shared WIDTH-bit ripple add/subtract unit time-shared between
//                two requesters. Round-robin arbitration in IDLE, one cycle of
//                combinational evaluation in EXEC (result registered at its
//                end), and a one-cycle valid/ack pulse in RESP.
//  Ports       : clk    - rising-edge clock
//                rst_n  - asynchronous active-low reset
//                bus    - addsub_arbiter_if.slave: req/op/a/b per client in,
//                         ack0/ack1/valid/result/carry/ovf/id/busy out
//  Revision    : 1.0  initial release
// ============================================================================
module addsub_arbiter #(
    parameter int WIDTH = 4
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    addsub_arbiter_if.slave  bus
);

    // ------------------------------------------------------------------------
    // Controller states
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_EXEC = 2'd1;
    localparam logic [1:0] c_RESP = 2'd2;

    logic [1:0]       r_state;
    logic             r_last_grant;

    // Operands captured at the grant edge; later requester changes are ignored
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_op;
    logic             r_grant_id;

    // Result registers: hold until the next EXEC overwrites them
    logic [WIDTH-1:0] r_result;
    logic             r_carry;
    logic             r_ovf;
    logic             r_id;

    logic             w_any_req;
    logic             w_grant;
    logic [WIDTH-1:0] w_b_x;
    logic [WIDTH:0]   w_sum;
    logic             w_ovf;

    // ------------------------------------------------------------------------
    // Round-robin arbitration. On a tie the client that was not granted last
    // wins; last_grant resets to 1 so client 0 wins the first tie.
    // ------------------------------------------------------------------------
    assign w_any_req = bus.req0 | bus.req1;

    always_comb begin
        w_grant = 1'b0;
        if (bus.req0 && bus.req1) begin
            w_grant = ~r_last_grant;
        end else if (bus.req1) begin
            w_grant = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Datapath: subtraction is a + ~b + 1, so the op bit doubles as the
    // inversion mask and the carry-in. The (WIDTH+1)-bit sum gives carry-out,
    // which for subtraction reads as "no borrow".
    // ------------------------------------------------------------------------
    assign w_b_x = r_b ^ {WIDTH{r_op}};
    assign w_sum = {1'b0, r_a} + {1'b0, w_b_x} + {{WIDTH{1'b0}}, r_op};

    // Overflow: both adder inputs share a sign and the sum's sign differs
    assign w_ovf = (r_a[WIDTH-1] == w_b_x[WIDTH-1]) &&
                   (w_sum[WIDTH-1] != r_a[WIDTH-1]);

    // ------------------------------------------------------------------------
    // Controller, grant and operand capture
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_IDLE;
            r_last_grant <= 1'b1;
            r_a          <= '0;
            r_b          <= '0;
            r_op         <= 1'b0;
            r_grant_id   <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_any_req) begin
                        r_a          <= w_grant ? bus.a1  : bus.a0;
                        r_b          <= w_grant ? bus.b1  : bus.b0;
                        r_op         <= w_grant ? bus.op1 : bus.op0;
                        r_grant_id   <= w_grant;
                        r_last_grant <= w_grant;
                        r_state      <= c_EXEC;
                    end
                end
                c_EXEC: begin
                    r_state <= c_RESP;
                end
                c_RESP: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Result registers, loaded at the end of EXEC. Reset clears them so an
    // aborted transaction leaves nothing behind.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result <= '0;
            r_carry  <= 1'b0;
            r_ovf    <= 1'b0;
            r_id     <= 1'b0;
        end else if (r_state == c_EXEC) begin
            r_result <= w_sum[WIDTH-1:0];
            r_carry  <= w_sum[WIDTH];
            r_ovf    <= w_ovf;
            r_id     <= r_grant_id;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs. valid/ack are decoded from RESP, so they are glitch-free
    // register-driven pulses and drop to 0 the instant reset is asserted.
    // ------------------------------------------------------------------------
    assign bus.valid  = (r_state == c_RESP);
    assign bus.ack0   = bus.valid & ~r_id;
    assign bus.ack1   = bus.valid &  r_id;
    assign bus.busy   = (r_state == c_EXEC) || (r_state == c_RESP);
    assign bus.result = r_result;
    assign bus.carry  = r_carry;
    assign bus.ovf    = r_ovf;
    assign bus.id     = r_id;

endmodule
`default_nettype wire
